// File: rtl/card_pkg.sv
// Shared deck constants, card types and index/value helpers for the card shoe.
// CARD_SHOE_ACE_HIGH_EN selects ace value 11 instead of 1.
package card_pkg;

    localparam int DECK_SIZE = 52;
    localparam int NUM_RANKS = 13;

    typedef logic [3:0] rank_t;
    typedef logic [1:0] suit_t;
    typedef logic [5:0] card_idx_t;

    typedef enum logic {
        IDLE  = 1'b0,
        PROBE = 1'b1
    } shoe_state_t;

    // Suit is idx/13; the deck is small enough that compares beat a divider.
    function automatic suit_t card_suit_f(input card_idx_t idx);
        suit_t s;
        if (idx >= 6'd39) begin
            s = 2'd3;
        end else if (idx >= 6'd26) begin
            s = 2'd2;
        end else if (idx >= 6'd13) begin
            s = 2'd1;
        end else begin
            s = 2'd0;
        end
        return s;
    endfunction

    function automatic rank_t card_rank_f(input card_idx_t idx);
        card_idx_t r;
        r = idx - (6'd13 * {4'd0, card_suit_f(idx)});
        return r[3:0];
    endfunction

    function automatic logic [4:0] card_value_f(input rank_t rank);
        logic [4:0] v;
        if (rank == 4'd0) begin
`ifdef CARD_SHOE_ACE_HIGH_EN
            v = 5'd11;
`else
            v = 5'd1;
`endif
        end else if (rank <= 4'd9) begin
            v = {1'b0, rank} + 5'd1;
        end else begin
            v = 5'd10;
        end
        return v;
    endfunction

endpackage

// File: rtl/card_lfsr.sv
// Free-running 6-bit maximal-length LFSR (x^6+x^5+1); reset loads a nonzero seed.
module card_lfsr (
    input  logic       Clock,
    input  logic       reset,
    input  logic [5:0] seed,
    output logic [5:0] q
);

    logic [5:0] q_q;
    logic [5:0] q_d;

    always_comb begin
        q_d = {q_q[4:0], q_q[5] ^ q_q[4]};
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            q_q <= seed;
        end else begin
            q_q <= q_d;
        end
    end

    assign q = q_q;

endmodule

// File: rtl/card_shoe.sv
// 52-card shoe dealing without replacement: LFSR picks a start card, linear probe skips dealt ones.
// Build option CARD_SHOE_ACE_HIGH_EN (in card_pkg) makes aces worth 11.
module card_shoe
    import card_pkg::*;
#(
    parameter logic [5:0] LFSR_SEED = 6'h2A
) (
    input  logic       Clock,
    input  logic       reset,
    input  logic       req,
    input  logic       shuffle,
    output logic       card_valid,
    output logic [4:0] card_value,
    output logic [3:0] card_rank,
    output logic [1:0] card_suit,
    output logic       busy,
    output logic       empty,
    output logic [5:0] cards_left
);

    localparam card_idx_t DECK_N   = 6'(DECK_SIZE);
    localparam card_idx_t LAST_IDX = 6'(DECK_SIZE - 1);

    logic [5:0]  lfsr;
    shoe_state_t state_q, state_d;
    card_idx_t   cand_q, cand_d;
    logic [51:0] dealt_q, dealt_d;
    logic [5:0]  left_q, left_d;
    logic        valid_q, valid_d;
    rank_t       rank_q, rank_d;
    suit_t       suit_q, suit_d;
    logic [4:0]  value_q, value_d;

    card_lfsr u_lfsr (
        .Clock (Clock),
        .reset (reset),
        .seed  (LFSR_SEED),
        .q     (lfsr)
    );

    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        dealt_d = dealt_q;
        left_d  = left_q;
        valid_d = 1'b0;
        rank_d  = rank_q;
        suit_d  = suit_q;
        value_d = value_q;

        // Shuffle overrides everything, including a probe in flight.
        if (shuffle) begin
            state_d = IDLE;
            dealt_d = '0;
            left_d  = DECK_N;
        end else begin
            case (state_q)
                IDLE: begin
                    if (req && (left_q != 6'd0)) begin
                        cand_d  = (lfsr >= DECK_N) ? (lfsr - DECK_N) : lfsr;
                        state_d = PROBE;
                    end
                end
                PROBE: begin
                    if (!dealt_q[cand_q]) begin
                        dealt_d[cand_q] = 1'b1;
                        rank_d  = card_rank_f(cand_q);
                        suit_d  = card_suit_f(cand_q);
                        value_d = card_value_f(card_rank_f(cand_q));
                        valid_d = 1'b1;
                        if (left_q != 6'd0) begin
                            left_d = left_q - 6'd1;
                        end
                        state_d = IDLE;
                    end else begin
                        cand_d = (cand_q == LAST_IDX) ? 6'd0 : (cand_q + 6'd1);
                    end
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge Clock) begin
        if (reset) begin
            state_q <= IDLE;
            dealt_q <= '0;
            left_q  <= DECK_N;
            valid_q <= 1'b0;
            rank_q  <= '0;
            suit_q  <= '0;
            value_q <= '0;
        end else begin
            state_q <= state_d;
            dealt_q <= dealt_d;
            left_q  <= left_d;
            valid_q <= valid_d;
            rank_q  <= rank_d;
            suit_q  <= suit_d;
            value_q <= value_d;
        end
    end

    // The probe pointer is only meaningful in PROBE, which always loads it first.
    always_ff @(posedge Clock) begin
        cand_q <= cand_d;
    end

    assign card_valid = valid_q;
    assign card_value = value_q;
    assign card_rank  = rank_q;
    assign card_suit  = suit_q;
    assign busy       = (state_q == PROBE);
    assign empty      = (left_q == 6'd0);
    assign cards_left = left_q;

endmodule
